// File: rtl/io_bus_pkg.sv
// Shared widths and state encodings for the I/O bus initiator.
// Imported by the initiator top and its interrupt handshake.
package io_bus_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_WR   = 2'd1,
    B_RD   = 2'd2,
    B_RSP  = 2'd3
  } bus_state_e;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_PEND = 2'd1,
    I_ACK  = 2'd2
  } intr_state_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/io_bus_initiator_intr.sv
// Interrupt request/acknowledge handshake toward the I/O module.
// Flags a sampled request to the core and counts acknowledges.
module io_intr_handshake
  import io_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       intr_req,
  input  logic       int_take,
  output logic       intr_ack,
  output logic       int_pend,
  output logic [7:0] int_count
);

  intr_state_e state_q, state_d;
  logic [7:0]  count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= I_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      I_IDLE: if (intr_req) state_d = I_PEND;
      I_PEND: begin
        if (int_take) begin
          state_d = I_ACK;
          count_d = count_q + 8'd1;
        end
      end
      // I/O drops the request the edge after it sees ack
      I_ACK:   if (!intr_req) state_d = I_IDLE;
      default: state_d = I_IDLE;
    endcase
  end

  always_comb begin
    int_pend = (state_q == I_PEND);
    intr_ack = (state_q == I_ACK);
  end

  assign int_count = count_q;

endmodule

// File: rtl/io_bus_initiator.sv
// Core-side initiator for the big-endian 4096x8 I/O space.
// Turns single-word requests into io_wr / io_rd bus cycles.
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_WAIT = 1
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  output logic              io_wr,
  output logic              io_rd,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              intr_req,
  output logic              intr_ack,
  output logic              int_pend,
  input  logic              int_take,
  output logic [7:0]        int_count
);

  localparam logic [2:0] RD_LAST = 3'(RD_WAIT);

  bus_state_e        state_q, state_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= B_IDLE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      B_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = ~word_aligned(req_addr[1:0]);
          if (!word_aligned(req_addr[1:0])) state_d = B_RSP;
          else if (req_wr)                  state_d = B_WR;
          else                              state_d = B_RD;
        end
      end
      B_WR: state_d = B_RSP;
      B_RD: begin
        cnt_d = cnt_q + 3'd1;
        // io_rdata has settled by the last held cycle
        if (cnt_q == RD_LAST) begin
          rdata_d = io_rdata;
          state_d = B_RSP;
        end
      end
      B_RSP:   state_d = B_IDLE;
      default: state_d = B_IDLE;
    endcase
  end

  always_comb begin
    req_ready = reset_n & (state_q == B_IDLE);
    io_wr     = (state_q == B_WR);
    io_rd     = (state_q == B_RD);
    rsp_valid = (state_q == B_RSP);
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = rsp_valid ? rdata_q : '0;
  end

  assign io_addr  = addr_q;
  assign io_wdata = wdata_q;

  io_intr_handshake u_intr (
    .clk       (sys_clk),
    .rst_n     (reset_n),
    .intr_req  (intr_req),
    .int_take  (int_take),
    .intr_ack  (intr_ack),
    .int_pend  (int_pend),
    .int_count (int_count)
  );

endmodule
